// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with two write ports, two read ports, an optional
// write-to-read bypass and a per-register busy scoreboard. Issue reserves a
// destination register (marks it busy). The late writeback port (load/memory)
// writes data and releases the busy bit. Decode reads operand data and busy
// flags to detect load-use hazards.
//
// Register 0 is hardwired to zero and is not stored. It is never busy.
//
// Parameters
//   XLEN    data width in bits
//   NREG    number of architectural registers (power of two, >= 2)
//   AW      register address width, derived from NREG
//   BYPASS  1: same-cycle write data is forwarded to the read ports
//           0: read ports show register contents only
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   rs1_addr, rs2_addr    read addresses
//   rs1_data, rs2_data    read data (combinational)
//   rs1_busy, rs2_busy    busy flag of the addressed register (combinational)
//   w0_en/addr/data       early writeback (ALU); never touches busy
//   w1_en/addr/data       late writeback (load/memory); also clears busy
//   rsv_en, rsv_addr      reserve request from issue; sets busy
//   busy_any              OR of all busy bits
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            w0_en,
    input  logic [AW-1:0]   w0_addr,
    input  logic [XLEN-1:0] w0_data,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_addr,
    input  logic [XLEN-1:0] w1_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            busy_any
);

    // -------------------------------------------------------------------------
    // State: registers 1..NREG-1 and their busy bits. Index 0 has no storage.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] mem_q [1:NREG-1];
    logic [XLEN-1:0] mem_d [1:NREG-1];
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;

    // Decoded write/reserve hits, one bit per stored register. Because the
    // loops only cover 1..NREG-1, an address of 0 never produces a hit.
    logic [NREG-1:1] w0_hit;
    logic [NREG-1:1] w1_hit;
    logic [NREG-1:1] rsv_hit;

    always_comb begin
        // NOTE: every always_comb output gets a default before any condition,
        // so no path leaves it unassigned and no latch is inferred.
        w0_hit  = '0;
        w1_hit  = '0;
        rsv_hit = '0;
        for (int i = 1; i < NREG; i++) begin
            w0_hit[i]  = w0_en  && (w0_addr  == AW'(i));
            w1_hit[i]  = w1_en  && (w1_addr  == AW'(i));
            rsv_hit[i] = rsv_en && (rsv_addr == AW'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Next-state for storage. w0 is applied last so it wins a same-address
    // collision with w1; the w1 data is dropped in that case.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
            if (w1_hit[i]) begin
                mem_d[i] = w1_data;
            end
            if (w0_hit[i]) begin
                mem_d[i] = w0_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state for the scoreboard. A reserve and a w1 release of the same
    // register in one cycle leave it busy: the new reservation belongs to a
    // younger instruction (back-to-back loads to one destination).
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d = rsv_hit | (busy_q & ~w1_hit);
    end

    // NOTE: the register array is reset along with the scoreboard because
    // reset must clear every architectural register to zero, not just the
    // control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                // NOTE: sequential state is assigned with <= only, so every
                // flop samples the pre-edge value of its _d input.
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_any = |busy_q;

    // -------------------------------------------------------------------------
    // Read ports. Both ports share one description via small arrays.
    // Address 0 matches no stored register and therefore reads 0, not busy.
    // -------------------------------------------------------------------------
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic            rd_busy [2];

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (rd_addr[p] == AW'(i)) begin
                    rd_data[p] = mem_q[i];
                    rd_busy[p] = busy_q[i];
                    if (BYPASS) begin
                        // Forwarding priority mirrors the write priority:
                        // w0 beats w1, both beat stored contents.
                        if (w0_hit[i]) begin
                            rd_data[p] = w0_data;
                        end else if (w1_hit[i]) begin
                            rd_data[p] = w1_data;
                        end
                        // A releasing w1 makes the operand available now,
                        // unless the same register is being re-reserved.
                        if (w1_hit[i] && !rsv_hit[i]) begin
                            rd_busy[p] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with two write ports, two read ports, optional write-to-read bypass and a per-register busy scoreboard. It sits between decode/issue and writeback in the pipelined core. Issue reserves a destination register; the late writeback port (load/memory) releases it. Decode reads operand data and busy flags from this block to detect load-use hazards.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, at least 2; register 0 is hardwired to zero
- AW, $clog2(NREG), register address width (derived)
- BYPASS, 1, 1: same-cycle write data is forwarded to read ports; 0: reads show register contents only

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rs1_busy, rs2_busy  out  1  busy flag of addressed register (combinational)
- w0_en  in  1  early writeback enable (ALU)
- w0_addr  in  AW  early writeback address
- w0_data  in  XLEN  early writeback data
- w1_en  in  1  late writeback enable (load/memory); also releases busy
- w1_addr  in  AW  late writeback address
- w1_data  in  XLEN  late writeback data
- rsv_en  in  1  reserve request from issue
- rsv_addr  in  AW  register to mark busy
- busy_any  out  1  OR of all busy bits (registered state, combinational OR)

## Operation
- Storage: NREG-1 registers of XLEN bits; index 0 is not stored. Reads of address 0 return 0 with busy 0.
- Writes: on the rising edge, w0 writes mem[w0_addr] if w0_en and w0_addr != 0. w1 behaves the same. Same address on both ports in one cycle: w0 data is written; w1 data is dropped. w1 still clears busy.
- Scoreboard: busy[i] is set on the edge when rsv_en and rsv_addr == i != 0. It is cleared on the edge when w1_en and w1_addr == i. w0 never touches busy.
- Simultaneous set and clear of the same register: set wins (busy stays 1). This covers back-to-back loads to the same destination.
- Reserve of an already-busy register: no change (stays 1). w1 to a non-busy register: data written, busy stays 0.
- Read port logic, per port with address a != 0:
  - BYPASS=1: if w0 hits a, output w0_data. Else if w1 hits a, output w1_data. Else output mem[a].
  - BYPASS=0: output mem[a].
- rsN_busy with BYPASS=1: busy[a] is masked to 0 when w1 hits a in the same cycle and rsv does not also target a. With BYPASS=0: raw busy[a].
- No illegal inputs: every address value is legal. Out-of-range is impossible because NREG is a power of two.

## Timing
- Reset (rst_n low, asynchronous): all registers go to 0 and all busy bits go to 0 immediately, independent of clk. Outputs then read 0; busy outputs and busy_any are 0.
- Reset release is sampled synchronously. The first edge with rst_n high performs normal writes and reserves.
- Reset asserted mid-operation discards pending writes and reservations in that cycle.
- Write latency: data written at edge N is visible on the read ports from edge N onward (storage path). With BYPASS=1 it is also visible combinationally during the cycle before edge N.
- Reserve latency: rsv at edge N makes busy visible after edge N. There is no same-cycle reserve bypass.
- Read path: purely combinational from addresses, write ports and state; no added cycles.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst_n low asynchronously mid-cycle. Required: rs1_data of x5 reads 0 before the next edge; busy_any = 0.
- x0 protection: w0 writes 0xFFFFFFFF to x0, and rsv_en targets x0. Required: x0 reads 0, rs1_busy = 0, busy_any = 0.
- Dual-write collision: w0 writes x7 = 0x11111111 and w1 writes x7 = 0x22222222 in the same cycle. Required: x7 reads 0x11111111 afterwards.
- Bypass: BYPASS=1, w1 writes x3 = 0xA5A5A5A5 while rs2_addr = 3. Required: rs2_data = 0xA5A5A5A5 in the same cycle. With BYPASS=0, rs2 shows the old value until after the edge.
- Scoreboard lifecycle: reserve x9, wait 3 cycles (rs1_busy = 1 each cycle), then w1 writes x9. Required: rs1_busy = 0 in the w1 cycle (BYPASS=1); busy_any = 0 after the edge.
- Set-wins: reserve x9 and w1 releases x9 in the same cycle. Required: busy[x9] = 1 after the edge and x9 holds w1 data.
